trivium_stream: RTL and testbench

// - Parametrised Trivium keystream generator. Produces WORD_W keystream bits per cycle.
// - Warm-up length is configurable. The caller requests a number of output words.
// - Output uses a valid/ready handshake with backpressure. Generation can be aborted.
// - Sits between the IV/key source and the key-derivation consumer that packs p/q keys.

---
 rtl/trivium_stream_pkg.sv | 42 ++++
 rtl/trivium_stream_round.sv | 36 +++
 rtl/trivium_stream.sv | 155 +++++++++++++++
 tb/tb_trivium_stream.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_stream_pkg.sv
// ----------------------------------------------------------------------------
// trivium_stream_pkg
// Shared constants, FSM state type and helpers for the Trivium keystream
// generator slice (trivium_stream top, trivium_round step).
// No ports: imported by the other files with import trivium_stream_pkg::*.
// ----------------------------------------------------------------------------
package trivium_stream_pkg;

   // Algorithm-fixed sizes and the default initialisation length
   localparam int KEY_WIDTH   = 80;
   localparam int IV_WIDTH    = 80;
   localparam int TRIV_STATE  = 288;
   localparam int TRIV_WARMUP = 1152;

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      GEN,
      DONE
   } trivium_fsm_t;

   // Word widths the datapath is allowed to be built with
   function automatic bit isLegalWordW(input int w);
      return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
             (w == 16) || (w == 32) || (w == 64);
   endfunction

   // Initial state: bit i of the vector holds s(i+1).
   // Key fills s1..s80, IV fills s94..s173, s286..s288 are set.
   function automatic logic [TRIV_STATE-1:0] loadState(
      input logic [KEY_WIDTH-1:0] keyIn,
      input logic [IV_WIDTH-1:0]  ivIn
   );
      logic [TRIV_STATE-1:0] s;
      s                  = '0;
      s[KEY_WIDTH-1:0]   = keyIn;
      s[93 +: IV_WIDTH]  = ivIn;
      s[287:285]         = 3'b111;
      return s;
   endfunction

endpackage

// File: rtl/trivium_stream_round.sv
// ----------------------------------------------------------------------------
// trivium_round
// One combinational Trivium step: produces the keystream bit of the current
// state and the shifted/updated next state.
// Ports:
//   st_i  in   TRIV_STATE  current state, bit i = s(i+1)
//   st_o  out  TRIV_STATE  state after one step
//   z_o   out  1           keystream bit of this step
// ----------------------------------------------------------------------------
module trivium_round
   import trivium_stream_pkg::*;
(
   input  logic [TRIV_STATE-1:0] st_i,
   output logic [TRIV_STATE-1:0] st_o,
   output logic                  z_o
);

   logic t1;
   logic t2;
   logic t3;

   // The output bit uses the linear taps only; the feedback terms then add
   // the AND taps and cross-register taps before each register takes its
   // new head bit and shifts up by one.
   always_comb begin
      t1   = st_i[65]  ^ st_i[92];
      t2   = st_i[161] ^ st_i[176];
      t3   = st_i[242] ^ st_i[287];
      z_o  = t1 ^ t2 ^ t3;
      t1   = t1 ^ (st_i[90]  & st_i[91])  ^ st_i[170];
      t2   = t2 ^ (st_i[174] & st_i[175]) ^ st_i[263];
      t3   = t3 ^ (st_i[285] & st_i[286]) ^ st_i[68];
      st_o = {st_i[286:177], t2, st_i[175:93], t1, st_i[91:0], t3};
   end

endmodule

// File: rtl/trivium_stream.sv
// ----------------------------------------------------------------------------
// trivium_stream
// Trivium keystream generator producing WORD_W bits per cycle after a
// configurable warm-up, for a requested number of words, with a valid/ready
// output handshake and abort.
// Ports:
//   clk        in   1          clock
//   rst        in   1          synchronous active-high reset
//   start      in   1          begin a run (sampled only in IDLE)
//   key        in   KEY_WIDTH  key, sampled with start
//   iv         in   IV_WIDTH   IV, sampled with start
//   num_words  in   NWORDS_W   words to emit, sampled with start
//   abort      in   1          end the current run, back to IDLE
//   out_data   out  WORD_W     keystream word, bit0 is the earliest z
//   out_valid  out  1          out_data valid
//   out_ready  in   1          consumer accepts the word
//   busy       out  1          high outside IDLE
//   done       out  1          one-cycle pulse after the last accepted word
// ----------------------------------------------------------------------------
module trivium_stream
   import trivium_stream_pkg::*;
#(
   parameter int WORD_W        = 8,
   parameter int WARMUP_ROUNDS = TRIV_WARMUP,
   parameter int NWORDS_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [KEY_WIDTH-1:0] key,
   input  logic [IV_WIDTH-1:0]  iv,
   input  logic [NWORDS_W-1:0]  num_words,
   input  logic                 abort,
   output logic [WORD_W-1:0]    out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done
);

   localparam int WARMUP_CYCLES = WARMUP_ROUNDS / WORD_W;
   localparam int WCNT_W        = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

   // Reject word widths the datapath does not support and warm-up lengths
   // that would not end on a cycle boundary.
   if (!isLegalWordW(WORD_W) || (WARMUP_ROUNDS < 0) || ((WARMUP_ROUNDS % WORD_W) != 0)) begin : g_badParams
      $error("trivium_stream: illegal WORD_W=%0d / WARMUP_ROUNDS=%0d", WORD_W, WARMUP_ROUNDS);
   end

   trivium_fsm_t          fsm_q, fsm_d;
   logic [TRIV_STATE-1:0] st_q, st_d;
   logic [NWORDS_W-1:0]   wordCnt_q, wordCnt_d;
   logic [NWORDS_W-1:0]   numWords_q, numWords_d;
   logic [WCNT_W-1:0]     warmCnt_q, warmCnt_d;

   logic [TRIV_STATE-1:0] chain [0:WORD_W];
   logic [WORD_W-1:0]     zWord;

   // WORD_W steps chained in one cycle; step j supplies keystream bit j.
   assign chain[0] = st_q;

   for (genvar j = 0; j < WORD_W; j++) begin : g_round
      trivium_round u_round (
         .st_i (chain[j]),
         .st_o (chain[j+1]),
         .z_o  (zWord[j])
      );
   end

   // State register with synchronous reset; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q      <= IDLE;
         st_q       <= '0;
         wordCnt_q  <= '0;
         numWords_q <= '0;
         warmCnt_q  <= '0;
      end else begin
         fsm_q      <= fsm_d;
         st_q       <= st_d;
         wordCnt_q  <= wordCnt_d;
         numWords_q <= numWords_d;
         warmCnt_q  <= warmCnt_d;
      end
   end

   // Next-state logic. The state only advances during warm-up and on an
   // accepted word, so a stalled word stays on out_data. Abort overrides
   // whatever the current state decided, including a same-cycle handshake,
   // and wipes the key material.
   always_comb begin
      fsm_d      = fsm_q;
      st_d       = st_q;
      wordCnt_d  = wordCnt_q;
      numWords_d = numWords_q;
      warmCnt_d  = warmCnt_q;

      unique case (fsm_q)
         IDLE: begin
            if (start) begin
               if (num_words != '0) begin
                  st_d       = loadState(key, iv);
                  numWords_d = num_words;
                  wordCnt_d  = '0;
                  warmCnt_d  = '0;
                  fsm_d      = (WARMUP_CYCLES == 0) ? GEN : WARMUP;
               end else begin
                  fsm_d = DONE;
               end
            end
         end
         WARMUP: begin
            st_d      = chain[WORD_W];
            warmCnt_d = warmCnt_q + 1'b1;
            if (warmCnt_q == WCNT_W'(WARMUP_CYCLES - 1)) begin
               fsm_d = GEN;
            end
         end
         GEN: begin
            if (out_ready) begin
               st_d      = chain[WORD_W];
               wordCnt_d = wordCnt_q + 1'b1;
               if (wordCnt_d == numWords_q) begin
                  fsm_d = DONE;
               end
            end
         end
         DONE: begin
            st_d      = '0;
            wordCnt_d = '0;
            fsm_d     = IDLE;
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase

      if ((fsm_q != IDLE) && abort) begin
         fsm_d     = IDLE;
         st_d      = '0;
         wordCnt_d = '0;
         warmCnt_d = '0;
      end
   end

   // Outputs decode the registered state only; out_data is forced to zero
   // outside GEN so nothing of the internal state leaks while idle.
   always_comb begin
      out_valid = (fsm_q == GEN);
      busy      = (fsm_q != IDLE);
      done      = (fsm_q == DONE);
      out_data  = (fsm_q == GEN) ? zWord : '0;
   end

endmodule

// File: tb/tb_trivium_stream.sv
// ----------------------------------------------------------------------------
// tb_trivium_stream
// Self-checking bench for trivium_stream: a bit-level software Trivium model
// supplies the expected keystream; one negedge process compares every valid
// word, and the directed/randomised runs check timing of valid, done and busy.
// ----------------------------------------------------------------------------
module tb_trivium_stream;
   import trivium_stream_pkg::*;

   localparam int W  = 8;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [79:0]   key;
   logic [79:0]   iv;
   logic [NW-1:0] numWords;
   logic          abort;
   logic [W-1:0]  outData;
   logic          outValid;
   logic          outReady;
   logic          busy;
   logic          done;

   logic          startX;
   logic          abortX;
   logic          readyX;
   logic [NW-1:0] numX1;
   logic [NW-1:0] numX64;
   logic [0:0]    data1;
   logic          valid1, busy1, done1;
   logic [63:0]   data64;
   logic          valid64, busy64, done64;

   int checks = 0;
   int errors = 0;
   int cycleNo = 0;
   int readyMode = 0;

   bit           mBits[$];
   logic [W-1:0] expWords[$];
   logic [W-1:0] acceptedLog[$];
   int           wordIdx = 0;
   bit           wideBits1[$];
   bit           wideBits64[$];
   int           done1Seen = 0;
   int           done64Seen = 0;

   logic         prevValid = 1'b0;
   logic         prevReady = 1'b0;
   logic         prevAbortRst = 1'b0;
   logic [W-1:0] prevData = '0;

   always #5 clk = ~clk;

   trivium_stream #(.WORD_W(W), .WARMUP_ROUNDS(TRIV_WARMUP), .NWORDS_W(NW)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
      .num_words(numWords), .abort(abort), .out_data(outData),
      .out_valid(outValid), .out_ready(outReady), .busy(busy), .done(done)
   );

   trivium_stream #(.WORD_W(1), .WARMUP_ROUNDS(TRIV_WARMUP), .NWORDS_W(NW)) dut1 (
      .clk(clk), .rst(rst), .start(startX), .key(key), .iv(iv),
      .num_words(numX1), .abort(abortX), .out_data(data1),
      .out_valid(valid1), .out_ready(readyX), .busy(busy1), .done(done1)
   );

   trivium_stream #(.WORD_W(64), .WARMUP_ROUNDS(TRIV_WARMUP), .NWORDS_W(NW)) dut64 (
      .clk(clk), .rst(rst), .start(startX), .key(key), .iv(iv),
      .num_words(numX64), .abort(abortX), .out_data(data64),
      .out_valid(valid64), .out_ready(readyX), .busy(busy64), .done(done64)
   );

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance one clock; inputs change 1 ns after the edge, ready by mode.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      cycleNo++;
      case (readyMode)
         0:       outReady = 1'b1;
         1:       outReady = ((cycleNo % 3) == 0);
         2:       outReady = 1'($urandom_range(0, 1));
         default: outReady = 1'b0;
      endcase
   endtask

   // Software Trivium on s[1..288] as written in the algorithm description.
   task automatic runModel(input logic [79:0] k, input logic [79:0] v, input int warm, input int nbits);
      bit s[1:288];
      bit t1, t2, t3, z;
      mBits.delete();
      for (int i = 1; i <= 288; i++) s[i] = 1'b0;
      for (int i = 0; i < 80; i++) begin
         s[i+1]  = k[i];
         s[i+94] = v[i];
      end
      s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
      for (int n = 0; n < warm + nbits; n++) begin
         t1 = s[66] ^ s[93];
         t2 = s[162] ^ s[177];
         t3 = s[243] ^ s[288];
         z  = t1 ^ t2 ^ t3;
         t1 = t1 ^ (s[91] & s[92]) ^ s[171];
         t2 = t2 ^ (s[175] & s[176]) ^ s[264];
         t3 = t3 ^ (s[286] & s[287]) ^ s[69];
         for (int i = 288; i > 178; i--) s[i] = s[i-1];
         s[178] = t2;
         for (int i = 177; i > 94; i--) s[i] = s[i-1];
         s[94] = t1;
         for (int i = 93; i > 1; i--) s[i] = s[i-1];
         s[1] = t3;
         if (n >= warm) mBits.push_back(z);
      end
   endtask

   function automatic logic [63:0] packChunk(input bit q[$], input int c);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if ((c * 64 + i) < q.size()) r[i] = q[c*64+i];
      end
      return r;
   endfunction

   // Per-cycle compare of the W=8 instance against the model words.
   always @(negedge clk) begin
      if (prevValid && !prevReady && !prevAbortRst) begin
         checkOutput("stall keeps valid", 64'(outValid), 64'd1);
         if (outValid) checkOutput("stall keeps data", 64'(outData), 64'(prevData));
      end
      if (outValid) begin
         if (wordIdx < expWords.size()) begin
            checkOutput($sformatf("word %0d", wordIdx), 64'(outData), 64'(expWords[wordIdx]));
         end else begin
            checkOutput("valid beyond request", 64'(outValid), 64'd0);
         end
         if (outReady && !abort && !rst) begin
            acceptedLog.push_back(outData);
            wordIdx++;
         end
      end
      prevValid    = outValid;
      prevReady    = outReady;
      prevData     = outData;
      prevAbortRst = abort || rst;
   end

   // Bit capture for the 1-bit and 64-bit instances (always ready).
   always @(negedge clk) begin
      if (valid1) wideBits1.push_back(data1[0]);
      if (valid64) begin
         for (int i = 0; i < 64; i++) wideBits64.push_back(data64[i]);
      end
      if (done1)  done1Seen++;
      if (done64) done64Seen++;
   end

   // Load the model for a run and pulse start; scrambles key/iv afterwards.
   task automatic startRun(input logic [79:0] k, input logic [79:0] v, input int num, input bit wide);
      logic [95:0] r;
      runModel(k, v, TRIV_WARMUP, num * W);
      expWords.delete();
      for (int w = 0; w < num; w++) begin
         logic [W-1:0] word;
         for (int b = 0; b < W; b++) word[b] = mBits[w*W+b];
         expWords.push_back(word);
      end
      wordIdx = 0;
      acceptedLog.delete();
      key      = k;
      iv       = v;
      numWords = NW'(num);
      start    = 1'b1;
      startX   = wide;
      stepCycle();
      start  = 1'b0;
      startX = 1'b0;
      r   = {$urandom(), $urandom(), $urandom()};
      key = r[79:0];
      r   = {$urandom(), $urandom(), $urandom()};
      iv  = r[79:0];
   endtask

   task automatic waitValid(output int n);
      n = 0;
      while (!outValid && n < TRIV_WARMUP / W + 20) begin
         stepCycle();
         n++;
      end
   endtask

   // A complete run with timing checks on latency, done and busy.
   task automatic applyStimulus(input logic [79:0] k, input logic [79:0] v, input int num, input int mode, input bit wide);
      int n;
      readyMode = mode;
      startRun(k, v, num, wide);
      if (num == 0) begin
         checkOutput("zero request done", 64'(done), 64'd1);
         checkOutput("zero request valid", 64'(outValid), 64'd0);
         stepCycle();
         checkOutput("zero request done width", 64'(done), 64'd0);
         checkOutput("zero request busy", 64'(busy), 64'd0);
         return;
      end
      checkOutput("busy after start", 64'(busy), 64'd1);
      waitValid(n);
      checkOutput("warmup latency", 64'(n), 64'(TRIV_WARMUP / W));
      n = 0;
      while (wordIdx < num && n < num * 20 + 50) begin
         stepCycle();
         n++;
      end
      checkOutput("words accepted", 64'(wordIdx), 64'(num));
      checkOutput("done after last word", 64'(done), 64'd1);
      checkOutput("valid drops at last word", 64'(outValid), 64'd0);
      checkOutput("busy during done", 64'(busy), 64'd1);
      stepCycle();
      checkOutput("done is one cycle", 64'(done), 64'd0);
      checkOutput("busy falls with done", 64'(busy), 64'd0);
   endtask

   logic [W-1:0] log1[$];
   bit           mainBits[$];
   logic [79:0]  kWide = 80'h0123456789ABCDEF0123;
   logic [79:0]  vWide = 80'hFEDCBA9876543210FEDC;

   initial begin
      int          n;
      logic [95:0] r;
      logic [79:0] kr, vr;
      logic [3:0]  pin;

      rst = 1'b1; start = 1'b0; abort = 1'b0; outReady = 1'b0;
      key = '0; iv = '0; numWords = '0;
      startX = 1'b0; abortX = 1'b0; readyX = 1'b1;
      numX1 = NW'(512); numX64 = NW'(8);
      repeat (2) stepCycle();
      checkOutput("reset valid", 64'(outValid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset data", 64'(outData), 64'd0);
      rst = 1'b0;
      stepCycle();

      // Pin the model with hand-derived first bits (no warm-up).
      runModel(80'd0, 80'd0, 0, 4);
      for (int i = 0; i < 4; i++) pin[i] = mBits[i];
      checkOutput("model pin zero state", 64'(pin), 64'h7);
      runModel(80'd1 << 65, 80'd0, 0, 1);
      checkOutput("model pin key s66", 64'(mBits[0]), 64'd0);
      runModel(80'd0, 80'd1 << 68, 0, 1);
      checkOutput("model pin iv s162", 64'(mBits[0]), 64'd0);

      $display("[TB] zero key/iv, 4 words, always ready");
      applyStimulus(80'd0, 80'd0, 4, 0, 1'b0);
      log1 = acceptedLog;

      $display("[TB] zero key/iv, 4 words, ready 1 in 3");
      applyStimulus(80'd0, 80'd0, 4, 1, 1'b0);
      checkOutput("stalled run length", 64'(acceptedLog.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < acceptedLog.size()) checkOutput($sformatf("stalled run word %0d", i), 64'(acceptedLog[i]), 64'(log1[i]));
      end

      $display("[TB] 512 bits on widths 1, 8, 64");
      wideBits1.delete(); wideBits64.delete();
      done1Seen = 0; done64Seen = 0;
      applyStimulus(kWide, vWide, 64, 0, 1'b1);
      mainBits.delete();
      foreach (acceptedLog[i]) for (int b = 0; b < W; b++) mainBits.push_back(acceptedLog[i][b]);
      n = 0;
      while ((busy1 || busy64) && n < 3000) begin
         stepCycle();
         n++;
      end
      checkOutput("wide runs finish", 64'(busy1 | busy64), 64'd0);
      checkOutput("W1 bit count", 64'(wideBits1.size()), 64'd512);
      checkOutput("W64 bit count", 64'(wideBits64.size()), 64'd512);
      checkOutput("W1 done pulses", 64'(done1Seen), 64'd1);
      checkOutput("W64 done pulses", 64'(done64Seen), 64'd1);
      runModel(kWide, vWide, TRIV_WARMUP, 512);
      for (int c = 0; c < 8; c++) begin
         checkOutput($sformatf("W8 chunk %0d", c),  packChunk(mainBits, c),   packChunk(mBits, c));
         checkOutput($sformatf("W1 chunk %0d", c),  packChunk(wideBits1, c),  packChunk(mBits, c));
         checkOutput($sformatf("W64 chunk %0d", c), packChunk(wideBits64, c), packChunk(mBits, c));
      end

      $display("[TB] abort after two words, then restart");
      readyMode = 0;
      startRun(kWide, vWide, 6, 1'b0);
      waitValid(n);
      n = 0;
      while (wordIdx < 2 && n < 50) begin
         stepCycle();
         n++;
      end
      checkOutput("two words before abort", 64'(wordIdx), 64'd2);
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("abort valid", 64'(outValid), 64'd0);
      checkOutput("abort busy", 64'(busy), 64'd0);
      checkOutput("abort done", 64'(done), 64'd0);
      repeat (3) begin
         stepCycle();
         checkOutput("no done after abort", 64'(done), 64'd0);
      end
      checkOutput("aborted word not counted", 64'(wordIdx), 64'd2);
      applyStimulus(kWide, vWide, 6, 0, 1'b0);

      $display("[TB] abort during warm-up");
      startRun(kWide, vWide, 3, 1'b0);
      repeat (10) stepCycle();
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("warmup abort busy", 64'(busy), 64'd0);

      $display("[TB] zero-word request");
      applyStimulus(kWide, vWide, 0, 0, 1'b0);

      $display("[TB] randomised runs");
      for (int t = 0; t < 4; t++) begin
         r  = {$urandom(), $urandom(), $urandom()};
         kr = r[79:0];
         r  = {$urandom(), $urandom(), $urandom()};
         vr = r[79:0];
         applyStimulus(kr, vr, int'($urandom_range(1, 12)), 2, 1'b0);
      end

      $display("[TB] reset mid warm-up with start held");
      readyMode = 0;
      startRun(kWide, vWide, 5, 1'b0);
      repeat (50) stepCycle();
      rst   = 1'b1;
      start = 1'b1;
      stepCycle();
      checkOutput("rst warmup valid", 64'(outValid), 64'd0);
      checkOutput("rst warmup busy", 64'(busy), 64'd0);
      checkOutput("rst warmup done", 64'(done), 64'd0);
      checkOutput("rst warmup data", 64'(outData), 64'd0);
      rst   = 1'b0;
      start = 1'b0;
      stepCycle();
      checkOutput("start during rst ignored", 64'(busy), 64'd0);

      $display("[TB] reset mid stall");
      readyMode = 3;
      startRun(kWide, vWide, 5, 1'b0);
      waitValid(n);
      checkOutput("stall run valid", 64'(outValid), 64'd1);
      repeat (4) stepCycle();
      rst = 1'b1;
      stepCycle();
      checkOutput("rst stall valid", 64'(outValid), 64'd0);
      checkOutput("rst stall busy", 64'(busy), 64'd0);
      checkOutput("rst stall done", 64'(done), 64'd0);
      checkOutput("rst stall data", 64'(outData), 64'd0);
      rst = 1'b0;
      readyMode = 0;
      repeat (2) stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
